// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the supported range of access latency.
package data_memory_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store lane enables and replicated store
// data, load lane extraction with sign/zero extension, alignment check.
module mem_lane_align
  import data_memory_ctrl_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [15:0] rshift;

  // Only the low halfword of the shifted word is ever needed for sub-word loads.
  assign rshift = 16'(rword >> {lane, 3'b000});

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = rword;
    misaligned  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{is_signed & rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{is_signed & rshift[15]}}, rshift[15:0]};
        misaligned  = lane[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        misaligned = |lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, word-organised data RAM behind a valid/ready request and
// response handshake with a fixed access latency; one request in flight.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;
  localparam int LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  r_write, r_signed;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             out_of_range, fault, access_now, misaligned;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes, rdata_ext;

  assign idx          = r_addr[IDX_W+1:2];
  assign out_of_range = |(r_addr >> (IDX_W + 2));
  assign fault        = misaligned | (r_size == 2'd3) | out_of_range;
  assign access_now   = (state == ACCESS) && (cnt == '0);

  mem_lane_align u_align (
    .lane        (r_addr[1:0]),
    .size        (r_size),
    .is_signed   (r_signed),
    .wdata       (r_wdata),
    .rword       (mem[idx]),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        cnt      <= CNT_W'(LAT_C - 1);
        r_write  <= req_write;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access_now) begin
        resp_err   <= fault;
        resp_rdata <= (fault || r_write) ? '0 : rdata_ext;
      end
    end
  end

  // Array is deliberately not reset; a reset in ACCESS leaves state != ACCESS,
  // so the pending store is abandoned.
  always_ff @(posedge clk) begin
    if (access_now && r_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus random
// traffic against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;
  localparam int NBYTES  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_mem [NBYTES];

  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain byte array, little-endian assembly, arithmetic checks.
  function automatic void model_access(input logic wr, input logic [31:0] addr,
                                       input logic [1:0] size, input logic sgn,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int n;
    n   = 1 << size;
    rd  = 32'h0;
    err = (size == 2'd3) || (addr % n != 0) || (addr >= NBYTES);
    if (err) return;
    for (int k = 0; k < n; k++) begin
      if (wr) model_mem[addr + k] = wdata[8*k +: 8];
      else    rd = rd | (32'(model_mem[addr + k]) << (8 * k));
    end
    if (!wr && sgn && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
  endfunction

  // Issue one request with resp_ready high; returns observed result and latency.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = size; req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_signed = 1'($urandom); req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: got ready/valid/err/busy=%b want 1000",
               {req_ready, resp_valid, resp_err, busy});
    end
    n_cmp++;
    if (resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h want 00000000", resp_rdata);
    end
  endtask

  task automatic init_mem();
    logic [31:0] rd, w; logic er, exp_er; logic [31:0] exp_rd; int lat; int errs;
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      model_access(1'b1, 32'(i * 4), 2'd2, 1'b0, w, exp_rd, exp_er);
      do_req(1'b1, 32'(i * 4), 2'd2, 1'b0, w, rd, er, lat);
      if (er !== 1'b0 || lat != LATENCY) errs++;
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL init_stores: %0d bad stores, want 0", errs);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  task automatic run_table(input string name, input vec_t v[$]);
    logic [31:0] rd, mrd; logic er, mer; int lat;
    foreach (v[i]) begin
      model_access(v[i].wr, v[i].addr, v[i].size, v[i].sgn, v[i].wdata, mrd, mer);
      do_req(v[i].wr, v[i].addr, v[i].size, v[i].sgn, v[i].wdata, rd, er, lat);
      n_cmp++;
      if (lat != LATENCY) begin
        n_bad++;
        $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, LATENCY);
      end
      n_cmp++;
      if (rd !== v[i].exp_rd || er !== v[i].exp_er) begin
        n_bad++;
        $display("FAIL %s[%0d] result: got rdata=%h err=%b want rdata=%h err=%b",
                 name, i, rd, er, v[i].exp_rd, v[i].exp_er);
      end
    end
  endtask

  task automatic test_word_byte_half();
    vec_t v[$];
    v.push_back('{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0});
    v.push_back('{1'b0, 32'h10, 2'd2, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0});
    v.push_back('{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0});
    v.push_back('{1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        32'h000000DE, 1'b0});
    v.push_back('{1'b1, 32'h12, 2'd1, 1'b0, 32'hAAAA1234, 32'h0, 1'b0});
    v.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'h1234BEEF, 1'b0});
    v.push_back('{1'b0, 32'h12, 2'd1, 1'b1, 32'h0,        32'h00001234, 1'b0});
    v.push_back('{1'b0, 32'h10, 2'd1, 1'b1, 32'h0,        32'hFFFFBEEF, 1'b0});
    run_table("word_byte_half", v);
  endtask

  task automatic test_errors();
    vec_t v[$];
    v.push_back('{1'b0, 32'h11,  2'd2, 1'b0, 32'h0,        32'h0, 1'b1});
    v.push_back('{1'b1, 32'h13,  2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1});
    v.push_back('{1'b1, 32'h11,  2'd2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1});
    v.push_back('{1'b0, 32'h10,  2'd3, 1'b0, 32'h0,        32'h0, 1'b1});
    v.push_back('{1'b1, 32'h10,  2'd3, 1'b0, 32'h55555555, 32'h0, 1'b1});
    v.push_back('{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'h1234BEEF, 1'b0});
    v.push_back('{1'b1, 32'h200, 2'd2, 1'b0, 32'h0BADF00D, 32'h0, 1'b1});
    v.push_back('{1'b0, 32'h200, 2'd2, 1'b0, 32'h0,        32'h0, 1'b1});
    v.push_back('{1'b0, 32'h0,   2'd2, 1'b0, 32'h0,
                  {model_mem[3], model_mem[2], model_mem[1], model_mem[0]}, 1'b0});
    v.push_back('{1'b1, 32'h1FC, 2'd2, 1'b0, 32'h87654321, 32'h0, 1'b0});
    v.push_back('{1'b0, 32'h1FF, 2'd0, 1'b1, 32'h0,        32'hFFFFFF87, 1'b0});
    v.push_back('{1'b0, 32'h1FC, 2'd2, 1'b0, 32'h0,        32'h87654321, 1'b0});
    run_table("errors", v);
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_rd, mrd; logic mer; int lat;
    model_access(1'b1, 32'h40, 2'd2, 1'b0, 32'h13579BDF, mrd, mer);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'h13579BDF;
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 32'h0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != LATENCY) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want %0d", lat, LATENCY);
    end
    hold_rd = resp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== hold_rd || resp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_stall[%0d]: got valid=%b ready=%b rdata=%h err=%b want 1 0 %h 0",
                 c, resp_valid, req_ready, resp_rdata, resp_err, hold_rd);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_handshake: got valid=%b ready=%b busy=%b want 0 1 0",
               resp_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second_accept: got ready=%b busy=%b want 0 1", req_ready, busy);
    end
    model_access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, mrd, mer);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != LATENCY || resp_rdata !== mrd || resp_err !== mer) begin
      n_bad++;
      $display("FAIL bp_second_resp: got lat=%0d rdata=%h err=%b want %0d %h %b",
               lat, resp_rdata, resp_err, LATENCY, mrd, mer);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd; logic er, mer; int lat;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1; #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, busy} !== 4'b1000 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_access: got ready/valid/err/busy=%b rdata=%h want 1000 00000000",
               {req_ready, resp_valid, resp_err, busy}, resp_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_access(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, mrd, mer);
    do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== mrd || er !== 1'b0 || lat != LATENCY) begin
      n_bad++;
      $display("FAIL reset_no_write: got rdata=%h err=%b lat=%0d want %h 0 %0d",
               rd, er, lat, mrd, LATENCY);
    end
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LATENCY) @(posedge clk);
    #1;
    reset = 1'b1; #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_resp: got valid=%b rdata=%h ready=%b want 0 00000000 1",
               resp_valid, resp_rdata, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd; logic er, mer, wr, sg; logic [1:0] sz; int lat;
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'h200 + 32'($urandom_range(0, 15));
        default: addr = 32'($urandom_range(0, NBYTES - 1));
      endcase
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 1);
      model_access(wr, addr, sz, sg, wd, mrd, mer);
      do_req(wr, addr, sz, sg, wd, rd, er, lat);
      n_cmp++;
      if (rd !== mrd || er !== mer || lat != LATENCY) begin
        n_bad++;
        $display("FAIL random[%0d] wr=%b addr=%h size=%0d sgn=%b: got rdata=%h err=%b lat=%0d want %h %b %0d",
                 i, wr, addr, sz, sg, rd, er, lat, mrd, mer, LATENCY);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    init_mem();
    test_word_byte_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory: byte-addressed, word-organised data RAM behind a valid/ready request/response handshake with configurable access latency. Supports byte, halfword and word loads and stores, with sign or zero extension. Flags misaligned and out-of-range accesses. Sits between the CPU datapath (ALU result as address, read-data-2 as store data) and the MemtoReg mux; lets a multi-cycle or stalling CPU wait on memory.

Parameters:
DATA_WIDTH, 32, word width in bits; must be 32.
DEPTH, 128, number of words; power of two.
ADDR_WIDTH, 32, byte-address width.
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_wdata  in  DATA_WIDTH  store data, right-aligned.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
resp_err  out  1  access faulted.
busy  out  1  high in any state except IDLE.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, latency counter = 0.
- The RAM array is not reset. Contents survive reset.
- State machine:
  - IDLE: req_ready = 1. On req_valid, capture all request fields, load counter = LATENCY-1, go to ACCESS.
  - ACCESS: req_ready = 0. Decrement counter each cycle. When it reaches 0, perform the array access at that edge, register the result, go to RESP. With LATENCY = 1, ACCESS lasts one cycle.
  - RESP: resp_valid = 1, resp_rdata and resp_err held stable. On resp_ready, clear resp_valid and go to IDLE.
- Latency and throughput:
  - resp_valid rises exactly LATENCY cycles after the accepting edge.
  - One request is outstanding at a time.
  - A new request is accepted in IDLE only, so the earliest next acceptance is the cycle after the response handshake.
- Addressing:
  - Word index = req_addr[log2(DEPTH)+1 : 2].
  - Byte lane = req_addr[1:0].
- Errors (resp_err = 1, no array write, resp_rdata = 0):
  - misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - req_size = 3.
  - out of range: any req_addr bit above log2(DEPTH)+1 is set.
- Stores:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian (lane 0 = bits 7:0).
  - Word writes all lanes.
  - Untouched lanes keep their value.
- Loads:
  - The selected lane(s) are right-aligned into resp_rdata.
  - Upper bits are sign-extended if req_signed, else zero-filled.
  - req_signed is ignored for word loads.
- Simultaneous events:
  - req_valid while not in IDLE is ignored; the requester must hold it.
  - Request fields change after acceptance have no effect.
- Reset mid-operation:
  - ACCESS before the final edge: no array write occurs.
  - RESP: the response is dropped.
  - The block returns to IDLE either way.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - state encoding IDLE / ACCESS / RESP.
  - the legal LATENCY range constants.
- One sub-module, mem_lane_align: purely combinational. It generates byte-lane write enables and shifted store data, aligns and extends load data, and computes the misaligned flag.
- The RAM array and FSM stay in data_memory_ctrl.

Test Plan:
- LATENCY = 2: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_valid exactly 2 cycles after each accept, rdata = 0xDEADBEEF, err = 0.
- After that word, load byte @0x13: signed -> rdata = 0xFFFFFFDE; unsigned -> rdata = 0x000000DE. Then store half 0x1234 @0x12 and load word @0x10 -> rdata = 0x1234BEEF.
- Load word @0x11, store half @0x13, and size = 3 -> resp_err = 1, rdata = 0, word @0x10 unchanged.
- With DEPTH = 128, load/store @0x200 -> resp_err = 1, no write; accesses @0x1FC succeed.
- Hold resp_ready = 0 for 5 cycles with req_valid asserted -> response stable, req_ready = 0, no second accept; accept occurs the cycle after the resp_ready handshake.
- Assert reset during ACCESS of store 0xCAFEF00D @0x20 -> outputs at reset values immediately; subsequent load @0x20 returns the prior value.
